// File: rtl/ei_axi_slave_mem.sv
// AXI4-style memory responder: independent write and read burst engines sharing one word array.
// Bursts that use an illegal burst code are carried out as INCR and raise the sticky ERR flag.
module ei_axi_slave_mem #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  ERR
);
    localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int IDX_WIDTH  = $clog2(MEM_DEPTH);
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic {W_IDLE, W_DATA} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    function automatic logic [2:0] eff_size(input logic [2:0] size);
        return (size > 3'(BYTE_SHIFT)) ? 3'(BYTE_SHIFT) : size;
    endfunction

    function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'd3) || ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic [1:0] legal_burst(input logic [1:0] burst, input logic [7:0] len);
        return bad_burst(burst, len) ? BURST_INCR : burst;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0]            len,
                                                        input logic [2:0]            size,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] container;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] incr;
        step      = ADDR_WIDTH'(1) << size;
        container = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
        base      = addr & ~(container - ADDR_WIDTH'(1));
        incr      = addr + step;
        case (burst)
            BURST_FIXED: return addr;
            BURST_WRAP:  return (incr == base + container) ? base : incr;
            default:     return incr;
        endcase
    endfunction

    function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return addr[BYTE_SHIFT +: IDX_WIDTH];
    endfunction

    // Ready outputs stay low for the cycle after any reset edge.
    logic running;
    always_ff @(posedge ACLK) begin
        running <= !ARESET;
    end

    w_state_t              w_state, w_state_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic                  aw_fire, w_fire, w_done;

    always_comb begin
        w_state_next = w_state;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        aw_fire      = 1'b0;
        w_fire       = 1'b0;
        w_done       = 1'b0;
        case (w_state)
            W_IDLE: begin
                AWREADY = running;
                aw_fire = AWVALID && running;
                if (aw_fire) w_state_next = W_DATA;
            end
            W_DATA: begin
                WREADY = running;
                w_fire = WVALID && running;
                w_done = w_fire && (WLAST || (w_cnt == w_len));
                if (w_done) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_next;
    end

    always_ff @(posedge ACLK) begin
        if (aw_fire) begin
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_size  <= eff_size(AWSIZE);
            w_burst <= legal_burst(AWBURST, AWLEN);
            w_cnt   <= 8'd0;
        end else if (w_fire) begin
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
        end
    end

    // A beat coinciding with reset is dropped along with the rest of its burst.
    always_ff @(posedge ACLK) begin
        if (w_fire && !ARESET) mem[word_idx(w_addr)] <= WDATA;
    end

    r_state_t              r_state, r_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic                  ar_fire, r_adv, r_end;

    always_comb begin
        r_state_next = r_state;
        ARREADY      = 1'b0;
        ar_fire      = 1'b0;
        r_adv        = 1'b0;
        r_end        = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = running;
                ar_fire = ARVALID && running;
                if (ar_fire) r_state_next = R_DATA;
            end
            R_DATA: begin
                if (RREADY) begin
                    r_end = (r_cnt == r_len);
                    r_adv = !r_end;
                    if (r_end) r_state_next = R_IDLE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_next;
    end

    // r_addr always points at the beat after the one currently on RDATA.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            RDATA  <= '0;
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
        end else if (ar_fire) begin
            RDATA   <= mem[word_idx(ARADDR)];
            RVALID  <= 1'b1;
            RLAST   <= (ARLEN == 8'd0);
            r_addr  <= next_addr(ARADDR, ARLEN, eff_size(ARSIZE), legal_burst(ARBURST, ARLEN));
            r_len   <= ARLEN;
            r_size  <= eff_size(ARSIZE);
            r_burst <= legal_burst(ARBURST, ARLEN);
            r_cnt   <= 8'd0;
        end else if (r_adv) begin
            RDATA  <= mem[word_idx(r_addr)];
            RLAST  <= ((r_cnt + 8'd1) == r_len);
            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
            r_cnt  <= r_cnt + 8'd1;
        end else if (r_end) begin
            RVALID <= 1'b0;
            RLAST  <= 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            ERR <= 1'b0;
        end else if ((aw_fire && bad_burst(AWBURST, AWLEN)) ||
                     (ar_fire && bad_burst(ARBURST, ARLEN)) ||
                     (w_done && (WLAST != (w_cnt == w_len)))) begin
            ERR <= 1'b1;
        end
    end

endmodule

// File: doc/ei_axi_slave_mem.md
Name: ei_axi_slave_mem

Overview:
AXI4-style memory-backed responder. It is the slave end of the AW/W/AR/R channel set driven by ei_axi_master. It accepts write bursts into an internal word array and returns read bursts from the same array. Write and read paths are independent FSMs sharing one memory. It sits opposite ei_axi_master in the layered bench as the reference responder, and stands alone as a synthesizable block.

Parameters:
ADDR_WIDTH, 32, byte address width of AWADDR/ARADDR.
DATA_WIDTH, 32, WDATA/RDATA width; power of 2, 8..128.
MEM_DEPTH, 256, number of DATA_WIDTH words; power of 2.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous reset, active-high.
AWADDR  in  ADDR_WIDTH  write burst start byte address.
AWLEN  in  8  write beats minus 1.
AWSIZE  in  3  log2 bytes per beat.
AWBURST  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved.
AWVALID  in  1  write address valid.
AWREADY  out  1  write address accepted.
WDATA  in  DATA_WIDTH  write beat data.
WLAST  in  1  final write beat marker.
WVALID  in  1  write data valid.
WREADY  out  1  write data accepted.
ARADDR, ARLEN, ARSIZE, ARBURST  in  ADDR_WIDTH/8/3/2  read burst attributes; same encodings as AW.
ARVALID  in  1  read address valid.
ARREADY  out  1  read address accepted.
RDATA  out  DATA_WIDTH  read beat data.
RLAST  out  1  final read beat.
RVALID  out  1  read data valid.
RREADY  in  1  master ready for read data.
ERR  out  1  sticky protocol-error flag.

Behaviour:
- Reset:
  - While ARESET is high at a rising edge, both FSMs go to IDLE.
  - AWREADY, WREADY, ARREADY, RVALID, RLAST and ERR are 0. RDATA is 0.
  - Memory contents are not cleared.
  - ARESET asserted mid-burst aborts the burst immediately. Remaining beats are not written or returned.
- Address handling:
  - Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH.
  - Effective size = min(AxSIZE, log2(DATA_WIDTH/8)).
  - No byte strobes. Every accepted write beat writes the full word.
- Next-address rules:
  - FIXED: address unchanged.
  - INCR: addr + (1<<size).
  - WRAP: container = (LEN+1)<<size, base = addr aligned down to container. The next address wraps to base when addr + (1<<size) reaches base + container.
  - Reserved burst code 3 is treated as INCR and sets ERR.
  - WRAP with LEN+1 not in {2,4,8,16} is treated as INCR and sets ERR.
- Write FSM:
  - States W_IDLE, W_DATA.
  - W_IDLE: AWREADY=1, WREADY=0. AWVALID&AWREADY captures address, len, size and burst, clears the beat counter, and moves to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Each WVALID&WREADY writes WDATA at the current word, advances the address and increments the counter.
  - The beat with counter==len returns to W_IDLE next cycle. If WLAST is not 1 on that beat, set ERR.
  - WLAST=1 with counter<len ends the burst early, returns to W_IDLE and sets ERR.
  - Min turnaround: address handshake in cycle N, first data accepted N+1. Back-to-back bursts lose one cycle in W_IDLE.
- Read FSM:
  - States R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1, RVALID=0. ARVALID&ARREADY captures attributes.
  - The memory word is registered into RDATA, so RVALID=1 in cycle N+1.
  - R_DATA: RDATA, RLAST and RVALID stay stable while RVALID&!RREADY.
  - On RVALID&RREADY: if counter==len, go to R_IDLE with RVALID=0 next cycle. Otherwise present the next beat next cycle, so full throughput is 1 beat/cycle with RREADY held high.
  - RLAST=1 only on beat counter==len.
- Shared memory:
  - Simultaneous write and read fetch of the same word in one cycle: the read returns the old data.
- ERR:
  - Set on any protocol violation above.
  - Cleared only by ARESET.

Test Plan:
- INCR write AWADDR=0x10, AWLEN=3, AWSIZE=2, data 0xA0..0xA3; then INCR read same -> RDATA 0xA0,0xA1,0xA2,0xA3, RLAST on 4th beat, ERR=0.
- WRAP write AWADDR=0x18, LEN=3, SIZE=2, data D0..D3 -> words 0x18,0x1C,0x10,0x14 hold D0..D3. Read back WRAP from 0x18 returns D0..D3 in order.
- FIXED write ADDR=0x40, LEN=2, data 1,2,3 -> word 0x40 = 3. Read with RREADY toggling 1,0,0,1 -> RDATA held stable during stall, RLAST on 3rd beat.
- Write with AWLEN=3 and WLAST on 2nd beat -> burst ends after 2 writes, AWREADY=1 next cycle, ERR=1. Cleared only after ARESET pulse.
- Assert ARESET on 2nd beat of an 8-beat read -> next cycle RVALID=0, RLAST=0, ARREADY=0. After release ARREADY=1, and a new read of previously written data returns the correct values.
- Simultaneous AW/AR to address 0x20, old value 0x55, new 0x99 -> first read beat 0x55; a subsequent read returns 0x99.
